// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: RV32 funct3 width/sign codes, the access FSM state encoding,
// fault codes reported on fault_code, and the misalignment helper.
package mem_pkg;

  // Load codes. Store codes reuse the same low two bits for the width.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAULT_MISALIGNED_LOAD  = 2'd0,
    FAULT_MISALIGNED_STORE = 2'd1,
    FAULT_BUS_TIMEOUT      = 2'd2
  } fault_code_t;

  // Width is taken from funct3[1:0]; any code that is neither byte nor
  // half is handled as a full word, both here and in the lane logic.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      LB[1:0]: mis = 1'b0;
      LH[1:0]: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane steering for the memory-access stage.
// Store side: builds byte enables and replicated write data from the
//   access width (st_size) and byte lane (st_lane).
// Load side: picks the addressed byte/half out of the raw bus word and
//   sign- or zero-extends it according to ld_funct3.
// Ports:
//   st_size, st_lane, st_data -> st_be, st_wdata
//   ld_funct3, ld_lane, ld_rdata -> ld_data
module lsu_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_lane,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN/8-1:0] st_be,
  output logic [XLEN-1:0]   st_wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_lane,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        ld_signed;

  // Sub-word stores replicate the datum across every lane so the memory
  // only has to honour the byte enables.
  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (st_size)
      LB[1:0]: begin
        st_be[st_lane] = 1'b1;
        for (int i = 0; i < XLEN / 8; i++) begin
          st_wdata[i*8 +: 8] = st_data[7:0];
        end
      end
      LH[1:0]: begin
        st_be[{st_lane[1], 1'b0} +: 2] = 2'b11;
        for (int i = 0; i < XLEN / 8; i++) begin
          st_wdata[i*8 +: 8] = st_data[(i % 2)*8 +: 8];
        end
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  // funct3[2] marks the unsigned variants.
  always_comb begin
    byte_val  = ld_rdata[{ld_lane, 3'b000} +: 8];
    half_val  = ld_rdata[{ld_lane[1], 4'b0000} +: 16];
    ld_signed = ~ld_funct3[2];
    ld_data   = ld_rdata;
    case (ld_funct3[1:0])
      LB[1:0]: ld_data = {{(XLEN-8){byte_val[7] & ld_signed}}, byte_val};
      LH[1:0]: ld_data = {{(XLEN-16){half_val[15] & ld_signed}}, half_val};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage with a valid/ready request bus and
// variable-latency responses.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_*                memory op from the execute stage (sampled in IDLE)
//   stall_m             holds upstream while an access is in flight
//   mem_req_*           registered request towards data memory
//   mem_resp_*          load response from data memory
//   wb_*                one-cycle load result pulse
//   fault_*             one-cycle fault pulse (misalignment or timeout)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [XLEN-1:0]       ex_addr,
  input  logic [XLEN-1:0]       ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  stall_m,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [XLEN-1:0]       mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [XLEN/8-1:0]     mem_req_be,
  input  logic                  mem_resp_valid,
  input  logic [XLEN-1:0]       mem_resp_rdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  fault_valid,
  output logic [1:0]            fault_code,
  output logic [XLEN-1:0]       fault_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state, state_next;
  logic                  accept, misaligned, resp_hit, timeout_hit;
  logic                  load_q;
  logic [2:0]            funct3_q;
  logic [XLEN-1:0]       addr_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      cnt;
  logic [XLEN/8-1:0]     st_be;
  logic [XLEN-1:0]       st_wdata, ld_data;

  // A simultaneous read+write is treated as a load, so ex_mem_read alone
  // decides the direction once an op is accepted.
  assign accept      = (state == ST_IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
  assign misaligned  = is_misaligned(ex_funct3, ex_addr[1:0]);
  assign resp_hit    = (state == ST_WAIT) && mem_resp_valid;
  assign timeout_hit = (state == ST_WAIT) && !mem_resp_valid && (cnt == CNT_LAST);

  assign stall_m       = (state != ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size   (ex_funct3[1:0]),
    .st_lane   (ex_addr[1:0]),
    .st_data   (ex_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_lane   (addr_q[1:0]),
    .ld_rdata  (mem_resp_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Misaligned accepts never leave IDLE; the fault is reported from the
  // datapath block instead.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && !misaligned) state_next = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_next = load_q ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (resp_hit || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request payload is captured at accept and held untouched until the
  // handshake. wb_valid/fault_valid default low so they only pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q        <= 1'b0;
      funct3_q      <= '0;
      addr_q        <= '0;
      rd_q          <= '0;
      cnt           <= '0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      fault_valid   <= 1'b0;
      fault_code    <= '0;
      fault_addr    <= '0;
    end else begin
      wb_valid    <= 1'b0;
      fault_valid <= 1'b0;
      if (accept) begin
        load_q   <= ex_mem_read;
        funct3_q <= ex_funct3;
        addr_q   <= ex_addr;
        rd_q     <= ex_rd;
        if (misaligned) begin
          fault_valid <= 1'b1;
          fault_code  <= ex_mem_read ? FAULT_MISALIGNED_LOAD : FAULT_MISALIGNED_STORE;
          fault_addr  <= ex_addr;
        end else begin
          mem_req_we    <= ~ex_mem_read;
          mem_req_addr  <= {ex_addr[XLEN-1:2], 2'b00};
          mem_req_wdata <= st_wdata;
          mem_req_be    <= st_be;
        end
      end
      if (state == ST_REQ && mem_req_ready) begin
        cnt <= '0;
      end
      if (resp_hit) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= ld_data;
      end else if (timeout_hit) begin
        fault_valid <= 1'b1;
        fault_code  <= FAULT_BUS_TIMEOUT;
        fault_addr  <= addr_q;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32, TIMEOUT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk, rst;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall_m, mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault_valid;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .ex_rd          (ex_rd),
    .stall_m        (stall_m),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .fault_valid    (fault_valid),
    .fault_code     (fault_code),
    .fault_addr     (fault_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  // Reference model: byte offset arithmetic on the RV32 access rules.
  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int size_bytes;
    size_bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (addr % size_bytes) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = addr % 4;
    case (f3[1:0])
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'd0:    return (w & 32'hFF) * 32'h01010101;
      2'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] shifted, v;
    shifted = rdata >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = shifted & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = shifted & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd4: v = shifted & 32'hFF;
      3'd5: v = shifted & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // One complete operation, starting and ending on a falling edge with the
  // DUT in IDLE. resp_delay counts silent WAIT cycles before the response;
  // resp_delay >= TIMEOUT means the response never comes.
  task automatic applyStimulus(input bit is_load, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input int ready_delay,
                               input int resp_delay, input logic [31:0] rdata);
    bit mis;
    mis = model_misaligned(f3, addr);
    ex_valid     = 1'b1;
    ex_mem_read  = is_load;
    ex_mem_write = !is_load;
    ex_funct3    = f3;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_rd        = rd;
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("wb_pulse_clear", wb_valid, 0);
    if (mis) begin
      checkOutput("mis_fault_valid", fault_valid, 1);
      checkOutput("mis_fault_code", fault_code, is_load ? 64'd0 : 64'd1);
      checkOutput("mis_fault_addr", fault_addr, addr);
      checkOutput("mis_no_req", mem_req_valid, 0);
      checkOutput("mis_no_stall", stall_m, 0);
      return;
    end
    checkOutput("fault_pulse_clear", fault_valid, 0);
    for (int k = 0; k <= ready_delay; k++) begin
      checkOutput("req_stall", stall_m, 1);
      checkOutput("req_valid", mem_req_valid, 1);
      checkOutput("req_we", mem_req_we, !is_load);
      checkOutput("req_addr", mem_req_addr, addr & 32'hFFFFFFFC);
      if (!is_load) begin
        checkOutput("req_be", mem_req_be, model_be(f3, addr));
        checkOutput("req_wdata", mem_req_wdata, model_wdata(f3, wdata));
      end
      mem_req_ready  = (k == ready_delay);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_rdata = $urandom;
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (!is_load) begin
      checkOutput("st_done_stall", stall_m, 0);
      checkOutput("st_done_req", mem_req_valid, 0);
      checkOutput("st_no_wb", wb_valid, 0);
      checkOutput("st_no_fault", fault_valid, 0);
      return;
    end
    for (int w = 1; w <= TIMEOUT; w++) begin
      checkOutput("wait_stall", stall_m, 1);
      checkOutput("wait_no_req", mem_req_valid, 0);
      if (w == resp_delay + 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
      end
      @(negedge clk);
      if (w == resp_delay + 1) break;
    end
    mem_resp_valid = 1'b0;
    checkOutput("ld_done_stall", stall_m, 0);
    if (resp_delay < TIMEOUT) begin
      checkOutput("ld_wb_valid", wb_valid, 1);
      checkOutput("ld_wb_rd", wb_rd, rd);
      checkOutput("ld_wb_data", wb_data, model_load(f3, addr, rdata));
      checkOutput("ld_no_fault", fault_valid, 0);
    end else begin
      checkOutput("to_fault_valid", fault_valid, 1);
      checkOutput("to_fault_code", fault_code, 2);
      checkOutput("to_fault_addr", fault_addr, addr);
      checkOutput("to_no_wb", wb_valid, 0);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          ld;
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    checkOutput("rst_stall", stall_m, 0);
    checkOutput("rst_req_valid", mem_req_valid, 0);
    checkOutput("rst_req_we", mem_req_we, 0);
    checkOutput("rst_req_addr", mem_req_addr, 0);
    checkOutput("rst_req_wdata", mem_req_wdata, 0);
    checkOutput("rst_req_be", mem_req_be, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_rd", wb_rd, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_fault_valid", fault_valid, 0);
    checkOutput("rst_fault_code", fault_code, 0);
    checkOutput("rst_fault_addr", fault_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checkOutput("stale_resp_idle", wb_valid, 0);
    checkOutput("stale_resp_stall", stall_m, 0);

    applyStimulus(1, 3'd2, 32'h100, 32'h0, 5'd7, 0, 0, 32'hDEADBEEF);
    applyStimulus(1, 3'd0, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80FF1234);
    applyStimulus(1, 3'd4, 32'h103, 32'h0, 5'd4, 0, 0, 32'h80FF1234);
    applyStimulus(1, 3'd5, 32'h102, 32'h0, 5'd5, 1, 2, 32'h80FF1234);
    applyStimulus(0, 3'd0, 32'h101, 32'hAB, 5'd0, 3, 0, 32'h0);
    applyStimulus(0, 3'd1, 32'h202, 32'h5566CAFE, 5'd0, 0, 0, 32'h0);
    applyStimulus(0, 3'd2, 32'h300, 32'hA5A5F00F, 5'd0, 2, 0, 32'h0);
    applyStimulus(1, 3'd2, 32'h102, 32'h0, 5'd9, 0, 0, 32'h0);
    applyStimulus(0, 3'd1, 32'h001, 32'h1234, 5'd0, 0, 0, 32'h0);
    applyStimulus(1, 3'd2, 32'h400, 32'h0, 5'd6, 0, TIMEOUT, 32'h0);
    applyStimulus(1, 3'd2, 32'h404, 32'h0, 5'd6, 0, TIMEOUT - 1, 32'hCAFEF00D);
    applyStimulus(1, 3'd1, 32'h406, 32'h0, 5'd0, 0, 1, 32'h8001ABCD);

    // Reset in WAIT, then a response the next cycle must be ignored.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'd2; ex_addr = 32'h500; ex_rd = 5'd11;
    @(negedge clk);
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkOutput("pre_rst_wait_stall", stall_m, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h77777777;
    checkOutput("rst_wait_stall", stall_m, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checkOutput("rst_wait_no_wb", wb_valid, 0);
    checkOutput("rst_wait_stall2", stall_m, 0);
    checkOutput("rst_wait_no_fault", fault_valid, 0);

    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom_range(0, 1));
      case ($urandom_range(0, ld ? 4 : 2))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((f3[1:0] == 2'd2) ? 32'h3 : {31'h0, f3[0]});
      applyStimulus(ld, f3, a, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 1), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the combinational memory-access stage. Sits between the execute/memory pipeline register and the data-memory bus.
- Replaces the fixed single-cycle `dout` path with a valid/ready request bus and variable-latency responses.
- Handles byte, half and word loads and stores with lane alignment, sign extension and misalignment detection.
- Adds a response timeout and back-pressures the pipeline through `stall_m`.

Parameters:
- XLEN, 32, data/address width; a multiple of 8, minimum 32.
- REG_ADDR_W, 5, destination register index width.
- TIMEOUT, 1023, maximum cycles spent in WAIT before a bus-error fault; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  memory op presented
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (ex_mem_read and ex_mem_write both high is illegal; treated as load)
- ex_funct3  in  3  RV32 width/sign code
- ex_addr  in  XLEN  effective address (alu_result)
- ex_wdata  in  XLEN  store data (rd2)
- ex_rd  in  REG_ADDR_W  load destination
- stall_m  out  1  hold execute stage and inputs
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_we  out  1  write
- mem_req_addr  out  XLEN  word-aligned address (low 2 bits zero)
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_be  out  XLEN/8  byte enables
- mem_resp_valid  in  1  load data valid
- mem_resp_rdata  in  XLEN  raw load word
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  REG_ADDR_W  destination
- wb_data  out  XLEN  aligned, extended load data
- fault_valid  out  1  one-cycle fault pulse
- fault_code  out  2  0 = misaligned load, 1 = misaligned store, 2 = bus timeout
- fault_addr  out  XLEN  faulting ex_addr

Behaviour:
- Reset: state IDLE. All outputs are 0. Timeout counter is 0. Reset takes priority over every other event in the same cycle.
- States: IDLE, REQ, WAIT.
- stall_m is combinational: high exactly when state is not IDLE.
- Inputs are sampled only in IDLE. Upstream holds ex_* stable while stall_m is high.
- Accept condition: IDLE and ex_valid and (ex_mem_read or ex_mem_write). On accept, latch op, funct3, addr, wdata and rd.
- Misalignment: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - On a misaligned accept, issue no bus request and stay IDLE.
  - Next cycle: fault_valid=1, fault_code=0 or 1, fault_addr=addr.
- Aligned accept: IDLE→REQ. mem_req_valid=1 from the next cycle, payload registered and stable until the handshake.
- Handshake (REQ with mem_req_ready):
  - Store: →IDLE. The store is complete; no wb_valid.
  - Load: →WAIT, counter cleared.
- mem_resp_valid is honoured only in WAIT and ignored in IDLE/REQ, including stale responses after reset.
- Load completion (WAIT with mem_resp_valid): →IDLE. Next cycle: wb_valid=1, wb_rd=latched rd, wb_data = extracted lane.
  - Lane = addr[1:0] bytes; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Timeout: the counter increments each WAIT cycle without a response.
  - Counter reaching TIMEOUT (TIMEOUT cycles in WAIT with no response, TIMEOUT≥1) →IDLE. Next cycle: fault_valid=1, fault_code=2.
  - A response arriving in that same cycle wins, and no fault is raised.
- Store lanes:
  - SB: be = 1<<addr[1:0], data byte replicated to all lanes.
  - SH: be = 0011 or 1100, halfword replicated.
  - SW: be = 1111.
- rd=0 loads perform the bus access and pulse wb_valid with wb_rd=0.
- Throughput: aligned store minimum 2 cycles; aligned load minimum 3 cycles to wb_valid.
- Back-to-back: a new op can be accepted in the same cycle state returns to IDLE.

Decomposition:
- mem_pkg: funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, fault_code enum.
- Sub-module lsu_align: combinational store be/wdata generation and load extraction/extension. Reused by the top FSM.

Test Plan:
- Bus ready always high, LW at 0x100, resp_rdata=0xDEADBEEF one cycle after handshake → wb_valid at cycle 3, wb_data=0xDEADBEEF, stall_m high for 2 cycles.
- LB at addr 0x103, rdata=0x80FF1234 → wb_data=0xFFFFFF80; LBU same → 0x00000080; LHU at 0x102 → 0x000080FF.
- SB at 0x101, wdata=0x000000AB, ready delayed 3 cycles → mem_req_be=0010, wdata=0xABABABAB, payload stable for all 3 wait cycles, no wb_valid.
- LW at 0x102 → no mem_req_valid; fault_valid next cycle, code 0, fault_addr=0x102. SH at 0x001 → fault code 1.
- Load with no response, TIMEOUT=4 → fault code 2 after 4 WAIT cycles. Repeat with resp_valid on the 4th WAIT cycle → wb_valid and no fault.
- rst asserted during WAIT, then resp_valid next cycle → state IDLE, response ignored, no wb_valid, stall_m low.
